// File: rtl/clk_div_mc_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Optional period counters are enabled with CLK_DIV_MC_PERIOD_CNT_EN.
package clk_div_mc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYPASS = 2'd1,
        DIVIDE = 2'd2
    } ch_state_t;

    localparam int unsigned MIN_DIV_RATIO = 2;
    localparam int unsigned PERIOD_CNT_W  = 16;

    // Ratios below the minimum select the undivided reference clock.
    function automatic logic ratio_divides(input logic [31:0] ratio);
        return ratio >= 32'(MIN_DIV_RATIO);
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: IDLE/BYPASS/DIVIDE control, period counter and tick.
// CLK_DIV_MC_PERIOD_CNT_EN adds a per-channel completed-period counter.
module clk_div_ch
    import clk_div_mc_pkg::*;
#(
    parameter int unsigned RATIO_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_sync,
    input  logic [RATIO_W-1:0] i_ratio,
    output logic               o_div_clk_c,
    output logic               o_tick
`ifdef CLK_DIV_MC_PERIOD_CNT_EN
    ,
    output logic [PERIOD_CNT_W-1:0] o_period_cnt
`endif
);

    ch_state_t          state_q, state_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [RATIO_W-1:0] act_ratio_q, act_ratio_d;
    logic               div_q, div_d;
    logic               tick_q, tick_d;

    logic               ratio_ok;
    logic               boundary;
    logic [RATIO_W-1:0] cnt_inc;
    logic [RATIO_W-1:0] high_cycles;

    assign ratio_ok    = ratio_divides(32'(i_ratio));
    assign boundary    = (state_q == DIVIDE) && (cnt_q == RATIO_W'(act_ratio_q - RATIO_W'(1)));
    assign cnt_inc     = RATIO_W'(cnt_q + RATIO_W'(1));
    assign high_cycles = RATIO_W'(act_ratio_q >> 1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            act_ratio_q <= '0;
            div_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_ratio_q <= act_ratio_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
        end
    end

    // Sync and a period boundary perform the same reload, so a coincident pair is harmless.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_ratio_d = act_ratio_q;
        div_d       = div_q;

        if (!i_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            div_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, BYPASS: begin
                    if (ratio_ok) begin
                        state_d     = DIVIDE;
                        act_ratio_d = i_ratio;
                        cnt_d       = '0;
                        div_d       = 1'b1;
                    end else begin
                        state_d = BYPASS;
                        cnt_d   = '0;
                        div_d   = 1'b0;
                    end
                end
                DIVIDE: begin
                    if (i_sync || boundary) begin
                        cnt_d = '0;
                        if (ratio_ok) begin
                            act_ratio_d = i_ratio;
                            div_d       = 1'b1;
                        end else begin
                            state_d = BYPASS;
                            div_d   = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        div_d = (cnt_inc < high_cycles);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    div_d   = 1'b0;
                end
            endcase
        end

        tick_d = (state_d == BYPASS) || (div_d && !div_q);
    end

    // Bypass passes the reference clock through, selected only by registered state.
    always_comb begin
        o_div_clk_c = div_q;
        if (state_q == BYPASS) begin
            o_div_clk_c = i_clk;
        end
    end

    assign o_tick = tick_q;

`ifdef CLK_DIV_MC_PERIOD_CNT_EN
    logic [PERIOD_CNT_W-1:0] period_cnt_q, period_cnt_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

    // Counts completed periods only; a sync restarts a period without completing one.
    always_comb begin
        period_cnt_d = period_cnt_q;
        if (state_d == IDLE) begin
            period_cnt_d = '0;
        end else if (i_en && boundary) begin
            period_cnt_d = PERIOD_CNT_W'(period_cnt_q + PERIOD_CNT_W'(1));
        end
    end

    assign o_period_cnt = period_cnt_q;
`endif

endmodule

// File: rtl/clk_div_mc.sv
// Multi-channel integer clock divider sharing one reference clock.
// Define CLK_DIV_MC_PERIOD_CNT_EN to expose per-channel period counters.
module clk_div_mc
    import clk_div_mc_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned RATIO_W = 8
) (
    input  logic                      i_ref_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clk_en,
    input  logic [NUM_CH-1:0]         i_ch_en,
    input  logic [NUM_CH*RATIO_W-1:0] i_div_ratio,
    input  logic                      i_sync,
    output logic [NUM_CH-1:0]         o_div_clk,
    output logic [NUM_CH-1:0]         o_tick
`ifdef CLK_DIV_MC_PERIOD_CNT_EN
    ,
    output logic [NUM_CH*PERIOD_CNT_W-1:0] o_period_cnt
`endif
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_ch #(
            .RATIO_W (RATIO_W)
        ) u_ch (
            .i_clk       (i_ref_clk),
            .i_rst_n     (i_rst_n),
            .i_en        (i_clk_en & i_ch_en[k]),
            .i_sync      (i_sync),
            .i_ratio     (i_div_ratio[k*RATIO_W +: RATIO_W]),
            .o_div_clk_c (o_div_clk[k]),
            .o_tick      (o_tick[k])
`ifdef CLK_DIV_MC_PERIOD_CNT_EN
            ,
            .o_period_cnt (o_period_cnt[k*PERIOD_CNT_W +: PERIOD_CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_clk_div_mc.sv
// Directed vector bench for clk_div_mc (4 channels, 8-bit ratios).
// Period counter checks run only when CLK_DIV_MC_PERIOD_CNT_EN is defined.
module tb_clk_div_mc;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        clk_en = 1'b0;
    logic [3:0]  ch_en  = 4'h0;
    logic [31:0] ratio  = 32'h0;
    logic        sync   = 1'b0;
    logic [3:0]  div_clk;
    logic [3:0]  tick;
`ifdef CLK_DIV_MC_PERIOD_CNT_EN
    logic [63:0] period_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clk_div_mc #(
        .NUM_CH  (4),
        .RATIO_W (8)
    ) dut (
        .i_ref_clk   (clk),
        .i_rst_n     (rst_n),
        .i_clk_en    (clk_en),
        .i_ch_en     (ch_en),
        .i_div_ratio (ratio),
        .i_sync      (sync),
        .o_div_clk   (div_clk),
        .o_tick      (tick)
`ifdef CLK_DIV_MC_PERIOD_CNT_EN
        ,
        .o_period_cnt (period_cnt)
`endif
    );

    typedef struct {
        logic        clk_en;
        logic [3:0]  ch_en;
        logic [31:0] ratio;
        logic        sync;
        logic [3:0]  exp_div;
        logic [3:0]  exp_tick;
    } vec_t;

    vec_t vecs[$];

    function void add(input logic ce, input logic [3:0] en, input logic [31:0] r,
                      input logic s, input logic [3:0] ed, input logic [3:0] et);
        vec_t v;
        v.clk_en   = ce;
        v.ch_en    = en;
        v.ratio    = r;
        v.sync     = s;
        v.exp_div  = ed;
        v.exp_tick = et;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive a vector, let one rising edge happen, then sample just after it.
    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            clk_en = vecs[i].clk_en;
            ch_en  = vecs[i].ch_en;
            ratio  = vecs[i].ratio;
            sync   = vecs[i].sync;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d div_clk", i), 32'(div_clk), 32'(vecs[i].exp_div));
            check($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].exp_tick));
        end
    endtask

    int seg_a, seg_b, seg_c;

    initial begin
        // Ratios 2,3,4,5 on channels 0..3 from a common enable.
        add(1, 4'hF, 32'h05040302, 0, 4'hF, 4'hF);
        add(1, 4'hF, 32'h05040302, 0, 4'hC, 4'h0);
        add(1, 4'hF, 32'h05040302, 0, 4'h1, 4'h1);
        add(1, 4'hF, 32'h05040302, 0, 4'h2, 4'h2);
        add(1, 4'hF, 32'h05040302, 0, 4'h5, 4'h5);
        add(1, 4'hF, 32'h05040302, 0, 4'hC, 4'h8);
        add(1, 4'hF, 32'h05040302, 0, 4'hB, 4'h3);
        add(1, 4'hF, 32'h05040302, 0, 4'h0, 4'h0);
        add(1, 4'hF, 32'h05040302, 0, 4'h5, 4'h5);
        add(1, 4'hF, 32'h05040302, 0, 4'h6, 4'h2);
        add(1, 4'hF, 32'h05040302, 0, 4'h9, 4'h9);
        add(1, 4'hF, 32'h05040302, 0, 4'h8, 4'h0);
        add(1, 4'hF, 32'h05040302, 0, 4'h7, 4'h7);
        seg_a = vecs.size();
        // Global disable, then ch0 ratio 4 changed to 6 while cnt=1.
        add(0, 4'hF, 32'h05040302, 0, 4'h0, 4'h0);
        add(1, 4'h1, 32'h00000004, 0, 4'h1, 4'h1);
        add(1, 4'h1, 32'h00000004, 0, 4'h1, 4'h0);
        add(1, 4'h1, 32'h00000006, 0, 4'h0, 4'h0);
        add(1, 4'h1, 32'h00000006, 0, 4'h0, 4'h0);
        add(1, 4'h1, 32'h00000006, 0, 4'h1, 4'h1);
        add(1, 4'h1, 32'h00000006, 0, 4'h1, 4'h0);
        add(1, 4'h1, 32'h00000006, 0, 4'h1, 4'h0);
        add(1, 4'h1, 32'h00000006, 0, 4'h0, 4'h0);
        add(1, 4'h1, 32'h00000006, 0, 4'h0, 4'h0);
        add(1, 4'h1, 32'h00000006, 0, 4'h0, 4'h0);
        add(1, 4'h1, 32'h00000006, 0, 4'h1, 4'h1);
        // Ratios 0 and 1 bypass.
        add(1, 4'h0, 32'h00000000, 0, 4'h0, 4'h0);
        add(1, 4'h3, 32'h00000100, 0, 4'h3, 4'h3);
        add(1, 4'h3, 32'h00000100, 0, 4'h3, 4'h3);
        seg_b = vecs.size();
        // ch0 leaves bypass with ratio 3; ch1 stays in bypass.
        add(1, 4'h3, 32'h00000103, 0, 4'h3, 4'h3);
        add(1, 4'h3, 32'h00000103, 0, 4'h2, 4'h2);
        add(1, 4'h3, 32'h00000103, 0, 4'h2, 4'h2);
        add(1, 4'h3, 32'h00000103, 0, 4'h3, 4'h3);
        // ch1/ch2 ratio 4, ch2 one cycle late, sync realigns them.
        add(1, 4'h0, 32'h00000000, 0, 4'h0, 4'h0);
        add(1, 4'h2, 32'h00040400, 0, 4'h2, 4'h2);
        add(1, 4'h6, 32'h00040400, 0, 4'h6, 4'h4);
        add(1, 4'h6, 32'h00040400, 0, 4'h4, 4'h0);
        add(1, 4'h6, 32'h00040400, 0, 4'h0, 4'h0);
        add(1, 4'h6, 32'h00040400, 1, 4'h6, 4'h6);
        add(1, 4'h6, 32'h00040400, 0, 4'h6, 4'h0);
        add(1, 4'h6, 32'h00040400, 0, 4'h0, 4'h0);
        add(1, 4'h6, 32'h00040400, 0, 4'h0, 4'h0);
        add(1, 4'h6, 32'h00040400, 0, 4'h6, 4'h6);
        // ch3 disabled during its high phase, then re-enabled.
        add(1, 4'h0, 32'h00000000, 0, 4'h0, 4'h0);
        add(1, 4'h8, 32'h06000000, 0, 4'h8, 4'h8);
        add(1, 4'h8, 32'h06000000, 0, 4'h8, 4'h0);
        add(1, 4'h0, 32'h06000000, 0, 4'h0, 4'h0);
        add(1, 4'h8, 32'h06000000, 0, 4'h8, 4'h8);
        add(1, 4'h8, 32'h06000000, 0, 4'h8, 4'h0);
        seg_c = vecs.size();

        repeat (2) @(posedge clk);
        #1;
        check("reset div_clk", 32'(div_clk), 32'h0);
        check("reset tick", 32'(tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, seg_b);

        // Bypass output follows the reference clock low phase too.
        @(negedge clk);
        #1;
        check("bypass low phase div_clk", 32'(div_clk[1:0]), 32'h0);
        check("bypass low phase tick", 32'(tick[1:0]), 32'h3);

        run(seg_b, seg_c);

        // Asynchronous reset mid-period pulls the output low without a clock edge.
        check("pre-reset ch3 high", 32'(div_clk[3]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset div_clk", 32'(div_clk), 32'h0);
        check("async reset tick", 32'(tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart div_clk", 32'(div_clk), 32'h8);
        check("restart tick", 32'(tick), 32'h8);

`ifdef CLK_DIV_MC_PERIOD_CNT_EN
        ch_en = 4'h1;
        ratio = 32'h00000002;
        @(posedge clk);
        #1;
        check("period_cnt start", 32'(period_cnt[15:0]), 32'h0);
        repeat (70000) @(posedge clk);
        #1;
        check("period_cnt 35000", 32'(period_cnt[15:0]), 32'h88B8);
        ch_en = 4'h0;
        @(posedge clk);
        #1;
        check("period_cnt idle clear", 32'(period_cnt[15:0]), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
